serial_tx_fifo: RTL
===================

// Module: serial_tx_fifo
// PURPOSE
//  Buffered 8N1 UART transmitter with proper flow control; companion to the receive path of serial.
//  The host pushes bytes into a FIFO. A framing FSM drains the FIFO onto the tx line, LSB first.
//  It supports back-to-back frames and reports full, level, busy and a sticky overflow flag.
// PARAMETERS
//  CLK_FREQ        50_000_000             input clock frequency, Hz
//  BAUD            9600                   line rate, bit/s
//  CLK_MUL         CLK_FREQ/BAUD          clocks per bit period (integer, >= 2)
//  CLK_MUL_WIDTH   15                     width of the bit-period counter; must hold CLK_MUL-1
//  FIFO_AW         4                      FIFO address width; depth = 2**FIFO_AW
// PORTS
//  clk      in   1           single clock, all logic on posedge
//  rst      in   1           asynchronous, active-low reset (0 = reset)
//  dat_t    in   8           byte to send, sampled when txe=1
//  txe      in   1           write strobe; push occurs when txe=1 and full=0
//  full     out  1           FIFO holds 2**FIFO_AW bytes
//  level    out  FIFO_AW+1   bytes queued, excluding the byte currently being shifted
//  busy     out  1           frame in progress or level != 0
//  ovf      out  1           sticky flag: a txe arrived while full=1
//  ovf_rst  in   1           synchronous clear of ovf
//  tx       out  1           serial line, registered, idles high
// BEHAVIOUR
//  Reset (rst=0, applied asynchronously):
//   - tx=1, full=0, level=0, busy=0, ovf=0, FSM=IDLE, FIFO pointers=0.
//   - Reset mid-frame aborts the frame and flushes the FIFO.
//  FIFO:
//   - full is derived from the level before the clock edge.
//   - A push with full=1 is dropped and sets ovf.
//   - Push and pop on the same edge leave level unchanged.
//   - Pop only occurs when level != 0.
//   - Pointers wrap modulo depth; level counts 0..2**FIFO_AW.
//  ovf:
//   - Set wins over ovf_rst when both occur on the same edge.
//   - Otherwise ovf_rst=1 clears it on the next edge.
//  FSM: IDLE, START, DATA, STOP. A bit counter (0..CLK_MUL-1) runs only outside IDLE.
//   - IDLE:  tx=1. If level != 0: pop head into shift reg, tx<=0, bitcnt<=0, go to START.
//   - START: after CLK_MUL clocks, tx<=shift[0], go to DATA with index 0.
//   - DATA:  every CLK_MUL clocks, shift right and drive the next bit.
//            After bit 7 has lasted CLK_MUL clocks, tx<=1 and go to STOP.
//   - STOP:  after CLK_MUL clocks:
//            - if level != 0: pop, tx<=0, go to START (no idle gap);
//            - else go to IDLE.
//  Timing:
//   - Every bit, including start and stop, is exactly CLK_MUL clocks.
//   - A frame is 10*CLK_MUL clocks.
//   - Latency: a byte written at edge E into an empty, idle block drives tx low at edge E+1.
//  busy:
//   - Registered. It falls on the same edge the FSM returns to IDLE with level=0.
//   - It rises on the edge after a push into an idle block.
//  txe is ignored by the FSM; it only affects the FIFO. dat_t is don't-care when txe=0.
// TESTING (bench uses CLK_FREQ=160, BAUD=10, so CLK_MUL=16; FIFO_AW=4)
//  1. Hold rst=0 with random inputs -> tx=1, level=0, full=0, busy=0, ovf=0 throughout.
//  2. Push 0xA5 once from idle:
//     - tx low one cycle later for 16 clocks;
//     - then 1,0,1,0,0,1,0,1 at 16 clocks each;
//     - then stop=1; busy falls after 160 clocks.
//  3. Push 0x00 then 0xFF on consecutive cycles -> two contiguous frames, 320 clocks, no idle between.
//  4. Push 18 bytes on consecutive cycles from idle:
//     - the first is popped, so level reaches 16 and full=1;
//     - the 18th push sets ovf;
//     - exactly 17 frames are sent, in order.
//  5. Drop rst to 0 mid-frame (in DATA bit 4):
//     - tx=1 immediately and level=0;
//     - after release, 0x3C is sent as a clean frame.
//  6. ovf_rst with no overflow -> ovf=0 next edge.
//     ovf_rst on the same edge as an overflowing push -> ovf stays 1.

Source files
------------

// File: rtl/serial_tx_fifo.sv
// -----------------------------------------------------------------------------
// serial_tx_fifo
//
// Buffered 8N1 UART transmitter. The host pushes bytes into a small FIFO; a
// framing FSM drains it onto the tx line, LSB first, one start bit, eight data
// bits and one stop bit, each exactly CLK_MUL clocks long. Queued bytes are
// sent back to back with no idle gap between frames.
//
// Ports
//   clk      in   1          single clock, all logic on posedge
//   rst      in   1          asynchronous, active-low reset (0 = reset)
//   dat_t    in   8          byte to send, sampled when txe=1
//   txe      in   1          write strobe; push occurs when txe=1 and full=0
//   full     out  1          FIFO holds 2**FIFO_AW bytes
//   level    out  FIFO_AW+1  bytes queued, excluding the byte being shifted
//   busy     out  1          frame in progress or level != 0 (registered)
//   ovf      out  1          sticky: a txe arrived while full=1
//   ovf_rst  in   1          synchronous clear of ovf (a new overflow wins)
//   tx       out  1          serial line, registered, idles high
// -----------------------------------------------------------------------------
module serial_tx_fifo #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 9600,
  parameter int CLK_MUL       = CLK_FREQ / BAUD,
  parameter int CLK_MUL_WIDTH = 15,
  parameter int FIFO_AW       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         dat_t,
  input  logic               txe,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               busy,
  output logic               ovf,
  input  logic               ovf_rst,
  output logic               tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = FIFO_AW + 1;

  localparam logic [LW-1:0]            LVL_FULL = LW'(DEPTH);
  localparam logic [CLK_MUL_WIDTH-1:0] BIT_LAST = CLK_MUL_WIDTH'(CLK_MUL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [LW-1:0]      level_q;
  logic               push;
  logic               pop;
  logic               fifo_nempty;
  logic [7:0]         head;

  // full comes straight from the registered level, so a push on the same edge
  // as a pop out of a full FIFO is still dropped.
  assign full        = (level_q == LVL_FULL);
  assign fifo_nempty = (level_q != '0);
  assign push        = txe && !full;
  assign head        = mem[rd_ptr];
  assign level       = level_q;

  // NOTE: the storage array has no reset; a flush only needs the pointers and
  // level cleared, and leaving the RAM unreset lets it map onto memory cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dat_t;
    end
  end

  // NOTE: all sequential state is updated with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      // Simultaneous push and pop leaves the level unchanged.
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overflow: a new overflow takes priority over the clear request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (txe && full) begin
      ovf <= 1'b1;
    end else if (ovf_rst) begin
      ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  state_t                   state_q, state_d;
  logic [CLK_MUL_WIDTH-1:0] bitcnt_q, bitcnt_d;
  logic [2:0]               idx_q, idx_d;
  logic [7:0]               shift_q, shift_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;
  logic                     bit_end;

  // Last clock of the current bit period.
  assign bit_end = (bitcnt_q == BIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;

    // The bit-period counter free-runs outside IDLE and restarts at every bit
    // boundary, so each state only has to look at bit_end.
    if (state_q != IDLE) begin
      bitcnt_d = bit_end ? '0 : bitcnt_q + CLK_MUL_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        tx_d     = 1'b1;
        bitcnt_d = '0;
        if (fifo_nempty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // shift_q[1] is the bit that lands in position 0 after the shift.
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          if (fifo_nempty) begin
            // Chain straight into the next start bit: no idle gap.
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    // The pre-edge level makes busy rise one edge after a push into an idle
    // block, and fall on the very edge the FSM drops back to IDLE empty.
    busy_d = (state_d != IDLE) || fifo_nempty;
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
